dff_bank_arbiter: RTL and testbench

- Controller that shares one WIDTH-bit bank of D flip-flops between two requesters.
- Grants writes round-robin and sequences the bank's load and clear strobes.
- Reads the bank's Q back after every load to verify it, and acknowledges the requester.
- Sits between requesting logic and the DFF bank; it is the only driver of the bank's D, load and clear controls.

---
 rtl/dff_arb_pkg.sv | 23 ++
 rtl/dff_arb_rr2.sv | 34 +++
 rtl/dff_bank_arbiter.sv | 168 ++++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dff_arb_pkg
// Description : Shared types and constants for the DFF bank arbiter.
//               - state_t : the five controller states (3-bit encoding)
//               - REQ_ID0 / REQ_ID1 : requester identifiers
// Revision    : 1.0 - initial release
// ============================================================================
package dff_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ZERO  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHECK = 3'd3,
    ST_ACK   = 3'd4
  } state_t;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dff_arb_rr2.sv
`default_nettype none
// ============================================================================
// Module      : dff_arb_rr2
// Description : Combinational two-way round-robin picker.
// Ports       : REQ0, REQ1  - request lines
//               LAST        - id of the most recently granted requester
//               grant_valid - at least one request is pending
//               grant_id    - requester to grant (meaningful when grant_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module dff_arb_rr2
  import dff_arb_pkg::*;
(
  input  logic REQ0,
  input  logic REQ1,
  input  logic LAST,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = REQ0 | REQ1;
    if (REQ0 && REQ1) begin
      // Contention: hand the grant to whoever did not win last time.
      grant_id = (LAST == REQ_ID0) ? REQ_ID1 : REQ_ID0;
    end else if (REQ1) begin
      grant_id = REQ_ID1;
    end else begin
      grant_id = REQ_ID0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dff_bank_arbiter
// Description : Shares one WIDTH-bit DFF bank between two requesters. Grants
//               writes round-robin, strobes the bank's load/clear controls,
//               verifies the bank's Q after each load and acknowledges the
//               requester. All outputs are registered.
// Ports       : CLK, CLR (async active-high reset)
//               REQ0/D0, REQ1/D1 - write requests and data
//               ZERO_REQ         - request to clear the bank
//               REG_Q            - bank readback
//               REG_D, REG_LD, REG_ZERO - bank controls
//               ACK0, ACK1       - completion pulses
//               BUSY, LAST, ERR  - status
//               CNT0, CNT1       - saturating ACK counters (DFF_ARB_STATS_EN)
// Options     : define DFF_ARB_STATS_EN to add the CNT0/CNT1 counters.
// Revision    : 1.0 - initial release
// ============================================================================
module dff_bank_arbiter
  import dff_arb_pkg::*;
#(
  parameter int WIDTH = 8
`ifdef DFF_ARB_STATS_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  input  logic             ZERO_REQ,
  input  logic [WIDTH-1:0] REG_Q,
  output logic [WIDTH-1:0] REG_D,
  output logic             REG_LD,
  output logic             REG_ZERO,
  output logic             ACK0,
  output logic             ACK1,
  output logic             BUSY,
  output logic             LAST,
  output logic             ERR
`ifdef DFF_ARB_STATS_EN
  , output logic [CNT_W-1:0] CNT0
  , output logic [CNT_W-1:0] CNT1
`endif
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ld_q, ld_d;
  logic             zero_q, zero_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             busy_q;
  logic             last_q, last_d;
  logic             err_q, err_d;

  logic             gnt_valid;
  logic             gnt_id;

  dff_arb_rr2 u_rr2 (
    .REQ0        (REQ0),
    .REQ1        (REQ1),
    .LAST        (last_q),
    .grant_valid (gnt_valid),
    .grant_id    (gnt_id)
  );

  // Strobes are computed one state ahead so that the registered outputs line
  // up with the state they belong to (REG_LD high while in LOAD, ACK high
  // while in ACK).
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ld_d    = 1'b0;
    zero_d  = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ZERO_REQ) begin
          state_d = ST_ZERO;
          zero_d  = 1'b1;
        end else if (gnt_valid) begin
          state_d = ST_LOAD;
          ld_d    = 1'b1;
          last_d  = gnt_id;
          data_d  = (gnt_id == REQ_ID1) ? D1 : D0;
        end
      end
      ST_ZERO:  state_d = ST_IDLE;
      ST_LOAD:  state_d = ST_CHECK;
      ST_CHECK: begin
        if (REG_Q != data_q) begin
          err_d = 1'b1;
        end
        state_d = ST_ACK;
        ack0_d  = (last_q == REQ_ID0);
        ack1_d  = (last_q == REQ_ID1);
      end
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ld_q    <= 1'b0;
      zero_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= REQ_ID1;  // requester 0 wins the first tie
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ld_q    <= ld_d;
      zero_q  <= zero_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      busy_q  <= (state_d != ST_IDLE);
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // The data register doubles as the bank's D drive, so D stays stable
  // outside LOAD.
  assign REG_D    = data_q;
  assign REG_LD   = ld_q;
  assign REG_ZERO = zero_q;
  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign BUSY     = busy_q;
  assign LAST     = last_q;
  assign ERR      = err_q;

`ifdef DFF_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Counters advance on the same edge that raises the ACK pulse.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (ack0_d && (cnt0_q != {CNT_W{1'b1}})) begin
        cnt0_q <= cnt0_q + CNT_W'(1);
      end
      if (ack1_d && (cnt1_q != {CNT_W{1'b1}})) begin
        cnt1_q <= cnt1_q + CNT_W'(1);
      end
    end
  end

  assign CNT0 = cnt0_q;
  assign CNT1 = cnt1_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dff_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dff_bank_arbiter
// Description : Scoreboard bench for dff_bank_arbiter. Stimulus pushes the
//               expected bank/ACK events; a monitor pops and compares them
//               whenever the DUT strobes REG_LD, REG_ZERO, ACK0 or ACK1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dff_bank_arbiter;

  localparam int WIDTH   = 8;
  localparam int EV_LD   = 0;
  localparam int EV_ZERO = 1;
  localparam int EV_ACK  = 2;

  logic             CLK = 1'b0;
  logic             CLR = 1'b1;
  logic             REQ0 = 1'b0;
  logic             REQ1 = 1'b0;
  logic             ZERO_REQ = 1'b0;
  logic [WIDTH-1:0] D0 = '0;
  logic [WIDTH-1:0] D1 = '0;
  logic [WIDTH-1:0] REG_Q;
  logic [WIDTH-1:0] REG_D;
  logic             REG_LD, REG_ZERO, ACK0, ACK1, BUSY, LAST, ERR;
`ifdef DFF_ARB_STATS_EN
  logic [1:0]       CNT0, CNT1;
`endif

  typedef struct {
    int         kind;
    logic       id;
    logic [7:0] data;
    logic       err;
    int         gap;   // required cycles since previous event, 0 = any
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_ev_cyc = 0;
  logic [7:0] bank = '0;
  logic       corrupt = 1'b0;

  dff_bank_arbiter #(
    .WIDTH (WIDTH)
`ifdef DFF_ARB_STATS_EN
    , .CNT_W (2)
`endif
  ) dut (
    .CLK      (CLK),
    .CLR      (CLR),
    .REQ0     (REQ0),
    .D0       (D0),
    .REQ1     (REQ1),
    .D1       (D1),
    .ZERO_REQ (ZERO_REQ),
    .REG_Q    (REG_Q),
    .REG_D    (REG_D),
    .REG_LD   (REG_LD),
    .REG_ZERO (REG_ZERO),
    .ACK0     (ACK0),
    .ACK1     (ACK1),
    .BUSY     (BUSY),
    .LAST     (LAST),
    .ERR      (ERR)
`ifdef DFF_ARB_STATS_EN
    , .CNT0   (CNT0)
    , .CNT1   (CNT1)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Ideal DFF bank; corrupt forces a stuck-at-zero readback.
  always @(posedge CLK) begin
    if (REG_ZERO)    bank <= '0;
    else if (REG_LD) bank <= REG_D;
  end
  assign REG_Q = corrupt ? 8'h00 : bank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void push(input int kind, input logic id, input logic [7:0] data,
                               input logic err, input int gap);
    ev_t e;
    e.kind = kind; e.id = id; e.data = data; e.err = err; e.gap = gap;
    exp_q.push_back(e);
  endfunction

  task automatic check_event(input int kind, input logic id, input logic [7:0] data);
    ev_t e;
    int  gap;
    bit  bad;
    checks++;
    gap = cyc - last_ev_cyc;
    last_ev_cyc = cyc;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: actual kind=%0d id=%0d data=%0h required none",
               kind, id, data);
    end else begin
      e = exp_q.pop_front();
      bad = (e.kind != kind) || (e.gap != 0 && e.gap != gap);
      if (kind == EV_LD)  bad = bad || (data !== e.data);
      if (kind == EV_ACK) bad = bad || (id !== e.id) || (ERR !== e.err) || (LAST !== e.id);
      if (bad) begin
        failures++;
        $display("FAIL event: actual kind=%0d id=%0d data=%0h err=%0d last=%0d gap=%0d required kind=%0d id=%0d data=%0h err=%0d gap=%0d",
                 kind, id, data, ERR, LAST, gap, e.kind, e.id, e.data, e.err, e.gap);
      end
    end
  endtask

  // Monitor: outputs are registered, so the falling edge sees stable values.
  always @(negedge CLK) begin
    if (!CLR) begin
      if (REG_LD)   check_event(EV_LD, LAST, REG_D);
      if (REG_ZERO) check_event(EV_ZERO, 1'b0, 8'h00);
      if (ACK0)     check_event(EV_ACK, 1'b0, 8'h00);
      if (ACK1)     check_event(EV_ACK, 1'b1, 8'h00);
    end
  end

  task automatic wait_ack(input logic id, input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      @(negedge CLK);
      n++;
      if ((id ? ACK1 : ACK0) === 1'b1) seen = 1;
    end
    chk("ack_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic do_write(input logic id, input logic [7:0] data, input logic err_exp);
    push(EV_LD, id, data, 1'b0, 0);
    push(EV_ACK, id, data, err_exp, 2);
    @(negedge CLK);
    if (id) begin D1 = data; REQ1 = 1'b1; end
    else    begin D0 = data; REQ0 = 1'b1; end
    wait_ack(id, 20);
    REQ0 = 1'b0;
    REQ1 = 1'b0;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_reg_d", REG_D, 0);
    chk("rst_reg_ld", REG_LD, 0);
    chk("rst_reg_zero", REG_ZERO, 0);
    chk("rst_ack0", ACK0, 0);
    chk("rst_ack1", ACK1, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_last", LAST, 1);
    chk("rst_err", ERR, 0);
    CLR = 1'b0;

    // Single write from requester 0
    do_write(1'b0, 8'hA5, 1'b0);
    chk("t1_last", LAST, 0);
    chk("t1_err", ERR, 0);
    chk("t1_busy", BUSY, 0);

    // Both requesters held: strict alternation starting with requester 0
    do_reset();
    push(EV_LD,  1'b0, 8'h11, 1'b0, 0);
    push(EV_ACK, 1'b0, 8'h11, 1'b0, 2);
    push(EV_LD,  1'b1, 8'h22, 1'b0, 2);
    push(EV_ACK, 1'b1, 8'h22, 1'b0, 2);
    push(EV_LD,  1'b0, 8'h11, 1'b0, 2);
    push(EV_ACK, 1'b0, 8'h11, 1'b0, 2);
    push(EV_LD,  1'b1, 8'h22, 1'b0, 2);
    push(EV_ACK, 1'b1, 8'h22, 1'b0, 2);
    @(negedge CLK);
    D0 = 8'h11; D1 = 8'h22; REQ0 = 1'b1; REQ1 = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge CLK);
      if (ACK0 || ACK1) n++;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    chk("t2_ack_count", n, 4);
    wait_drain(10);
    @(negedge CLK);
    chk("t2_busy", BUSY, 0);

    // Clear together with a request: clear first, then the write
    push(EV_ZERO, 1'b0, 8'h00, 1'b0, 0);
    push(EV_LD,   1'b1, 8'h5A, 1'b0, 2);
    push(EV_ACK,  1'b1, 8'h5A, 1'b0, 2);
    @(negedge CLK);
    D1 = 8'h5A; REQ1 = 1'b1; ZERO_REQ = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (REG_ZERO) seen = 1;
    end
    ZERO_REQ = 1'b0;
    chk("t3_zero_seen", {31'd0, seen}, 1);
    wait_ack(1'b1, 20);
    REQ1 = 1'b0;
    @(negedge CLK);
    chk("t3_err", ERR, 0);

    // Readback mismatch sets a sticky ERR that survives good writes
    corrupt = 1'b1;
    do_write(1'b0, 8'h3C, 1'b1);
    corrupt = 1'b0;
    chk("t4_err_set", ERR, 1);
    do_write(1'b1, 8'h81, 1'b1);
    chk("t4_err_sticky", ERR, 1);
    do_reset();
    chk("t4_err_cleared", ERR, 0);

    // Reset during CHECK aborts without ACK; held request is re-granted
    push(EV_LD, 1'b0, 8'h77, 1'b0, 0);
    @(negedge CLK);
    D0 = 8'h77; REQ0 = 1'b1;
    seen = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge CLK);
      if (REG_LD) seen = 1;
    end
    chk("t5_ld_seen", {31'd0, seen}, 1);
    @(posedge CLK);
    #2 CLR = 1'b1;
    #1;
    chk("t5_clr_ack0", ACK0, 0);
    chk("t5_clr_reg_d", REG_D, 0);
    chk("t5_clr_busy", BUSY, 0);
    chk("t5_clr_last", LAST, 1);
    @(negedge CLK);
    push(EV_LD,  1'b0, 8'h77, 1'b0, 0);
    push(EV_ACK, 1'b0, 8'h77, 1'b0, 2);
    CLR = 1'b0;
    wait_ack(1'b0, 20);
    REQ0 = 1'b0;
    @(negedge CLK);
    chk("t5_last", LAST, 0);

`ifdef DFF_ARB_STATS_EN
    // Counter saturation at CNT_W=2
    do_reset();
    for (int k = 0; k < 5; k++) do_write(1'b0, 8'(k + 1), 1'b0);
    chk("t6_cnt0", CNT0, 3);
    chk("t6_cnt1", CNT1, 0);
`endif

    wait_drain(20);
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
